// File: rtl/sys_dma_ctrl_if.sv
// Bus bundle for sys_dma_ctrl: CPU register port, CPU halt, and DMA memory master port.
// The master modport is the controller; the slave modport is the system side (CPU, bus mux, RAM).
interface sys_dma_ctrl_if;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic        cpu_rdy;
  logic        reg_sel;
  logic [7:0]  reg_do;
  logic        bus_grant;
  logic [15:0] mem_ab;
  logic [7:0]  mem_do;
  logic        mem_we;
  logic [7:0]  mem_di;
  logic        dma_irq;

  modport master (
    input  cpu_ab, cpu_do, cpu_we, mem_di,
    output cpu_rdy, reg_sel, reg_do, bus_grant, mem_ab, mem_do, mem_we, dma_irq
  );

  modport slave (
    output cpu_ab, cpu_do, cpu_we, mem_di,
    input  cpu_rdy, reg_sel, reg_do, bus_grant, mem_ab, mem_do, mem_we, dma_irq
  );
endinterface

// File: rtl/sys_dma_ctrl.sv
// CPU-programmed block-copy DMA controller for the 6502 system bus.
// The CPU programs SRC/DST/LEN, sets START; the controller halts the CPU,
// takes the bus, copies bytes through synchronous memory, then releases.
// Optional feature macro: DMA_FILL_EN enables the constant-fill mode (CTRL b2),
// where every destination byte receives SRC_LO and the read phase is skipped.
module sys_dma_ctrl #(
  parameter logic [15:0] BASE_ADDR = 16'h1010
) (
  input logic           cclk,
  input logic           reset,
  sys_dma_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, HOLD, RD, CAP, WR, REL} state_t;

  state_t      state;
  logic [15:0] src;
  logic [15:0] dst;
  logic [7:0]  len;
  logic [8:0]  cnt;
  logic        ien;
  logic        done;
  logic        busy;
  logic        fill;
  logic [15:0] off_full;
  logic [2:0]  off;
  logic        in_win;
  logic        wr_hit;
  logic        ctrl_start;
  logic        ctrl_clr;
  logic [7:0]  rd_data;

`ifdef DMA_FILL_EN
  logic fill_q;
  assign fill = fill_q;
`else
  assign fill = 1'b0;
`endif

  // The window spans 8 offsets from BASE_ADDR; offsets 6 and 7 are unmapped and read 0.
  assign off_full   = bus.cpu_ab - BASE_ADDR;
  assign in_win     = (off_full[15:3] == 13'd0);
  assign off        = off_full[2:0];
  assign wr_hit     = in_win & bus.cpu_we;
  assign ctrl_start = bus.cpu_do[0];
  assign ctrl_clr   = bus.cpu_do[7] | bus.cpu_do[0];
  assign busy       = (state != IDLE);

  // Register read mux feeding the registered CPU read port.
  always_comb begin
    rd_data = 8'h00;
    case (off)
      3'd0:    rd_data = src[7:0];
      3'd1:    rd_data = src[15:8];
      3'd2:    rd_data = dst[7:0];
      3'd3:    rd_data = dst[15:8];
      3'd4:    rd_data = len;
      3'd5:    rd_data = {done, busy, 3'b000, fill, ien, 1'b0};
      default: rd_data = 8'h00;
    endcase
  end

  // Register file, transfer FSM and all registered bus outputs.
  always_ff @(posedge cclk) begin
    if (reset) begin
      state         <= IDLE;
      src           <= 16'h0000;
      dst           <= 16'h0000;
      len           <= 8'h00;
      cnt           <= 9'd0;
      ien           <= 1'b0;
      done          <= 1'b0;
`ifdef DMA_FILL_EN
      fill_q        <= 1'b0;
`endif
      bus.cpu_rdy   <= 1'b1;
      bus.reg_sel   <= 1'b0;
      bus.reg_do    <= 8'h00;
      bus.bus_grant <= 1'b0;
      bus.mem_ab    <= 16'h0000;
      bus.mem_do    <= 8'h00;
      bus.mem_we    <= 1'b0;
      bus.dma_irq   <= 1'b0;
    end else begin
      bus.reg_sel <= in_win & ~bus.cpu_we;
      bus.reg_do  <= (in_win & ~bus.cpu_we) ? rd_data : 8'h00;

      case (state)
        IDLE: begin
          // Register writes are only accepted here; the CPU is halted otherwise.
          if (wr_hit) begin
            case (off)
              3'd0: src[7:0]  <= bus.cpu_do;
              3'd1: src[15:8] <= bus.cpu_do;
              3'd2: dst[7:0]  <= bus.cpu_do;
              3'd3: dst[15:8] <= bus.cpu_do;
              3'd4: len       <= bus.cpu_do;
              3'd5: begin
                ien <= bus.cpu_do[1];
`ifdef DMA_FILL_EN
                fill_q <= bus.cpu_do[2];
`endif
                if (ctrl_clr) done <= 1'b0;
                bus.dma_irq <= bus.cpu_do[1] & done & ~ctrl_clr;
                if (ctrl_start) begin
                  state       <= HOLD;
                  bus.cpu_rdy <= 1'b0;
                  cnt         <= (len == 8'h00) ? 9'd256 : {1'b0, len};
                end
              end
              default: ;
            endcase
          end
        end

        HOLD: begin
          // Guard cycle over: take the bus.
          bus.bus_grant <= 1'b1;
          if (fill) begin
            bus.mem_ab <= dst;
            bus.mem_do <= src[7:0];
            bus.mem_we <= 1'b1;
            state      <= WR;
          end else begin
            bus.mem_ab <= src;
            state      <= RD;
          end
        end

        RD: state <= CAP;

        CAP: begin
          // Read data is valid now; it becomes the write data for the WR cycle.
          bus.mem_do <= bus.mem_di;
          bus.mem_ab <= dst;
          bus.mem_we <= 1'b1;
          state      <= WR;
        end

        WR: begin
          dst <= dst + 16'd1;
          cnt <= cnt - 9'd1;
          if (!fill) src <= src + 16'd1;
          if (cnt == 9'd1) begin
            bus.bus_grant <= 1'b0;
            bus.mem_we    <= 1'b0;
            state         <= REL;
          end else if (fill) begin
            bus.mem_ab <= dst + 16'd1;
          end else begin
            bus.mem_ab <= src + 16'd1;
            bus.mem_we <= 1'b0;
            state      <= RD;
          end
        end

        REL: begin
          bus.cpu_rdy <= 1'b1;
          done        <= 1'b1;
          bus.dma_irq <= ien;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
